// File: rtl/cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_memory_responder
// Description : Memory-side responder for the CPU memory interface. Holds a
//               DEPTH x DATA_WIDTH RAM that the CPU reads combinationally over
//               the shared tristate bus and writes on a detected mem_clk rise.
//               A host loader port preloads programs, and a clear FSM can
//               zero-fill the RAM after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_memory_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_clk,
  input  logic [ADDR_WIDTH-1:0] addr_bus,
  input  logic                  c_ri,
  input  logic                  c_ro,
  inout  wire  [DATA_WIDTH-1:0] bus,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ack,
  output logic                  ready,
  output logic                  conflict,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  // Two states only: zero-filling after reset, or serving CPU and loader.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Entry state after reset depends on whether the RAM is zero-filled.
  localparam state_t C_RESET_STATE = state_t'(CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE);

  // Last address written by the clear sweep; the sweep leaves CLEAR on that edge.
  localparam logic [ADDR_WIDTH-1:0] C_CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  mem_clk_q;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  // mem_clk is a level from the CPU; only its rising edge counts as a strobe,
  // so holding it high for several clocks yields exactly one access.
  logic strobe;
  logic cpu_rd_req;
  logic cpu_wr_req;
  logic cpu_both_req;
  logic wr_commit;
  logic rd_serve;
  logic conflict_hit;
  logic load_commit;
  logic load_collides;

  assign strobe       = mem_clk & ~mem_clk_q;
  assign cpu_rd_req   = c_ro & ~c_ri;
  assign cpu_wr_req   = c_ri & ~c_ro;
  assign cpu_both_req = c_ri & c_ro;

  // Every CPU-side effect is qualified by ready, so nothing happens during CLEAR.
  assign wr_commit    = ready & strobe & cpu_wr_req;
  assign rd_serve     = ready & strobe & cpu_rd_req;
  assign conflict_hit = ready & strobe & cpu_both_req;

  // A loader write that lands on the same address as a committing CPU write
  // loses; the missing ack tells the host to retry.
  assign load_collides = wr_commit & (load_addr == addr_bus);
  assign load_commit   = ready & load_we & ~load_collides;

  // --------------------------------------------------------------------------
  // Bus drive
  // --------------------------------------------------------------------------
  // Zero-latency read: the RAM word follows addr_bus directly, and the bus is
  // released the moment c_ro drops, c_ri joins it, or ready falls (including
  // asynchronously on reset, since ready is cleared by the async reset).
  assign bus = (ready && cpu_rd_req) ? mem[addr_bus] : {DATA_WIDTH{1'bz}};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  // Sweep clr_addr across the RAM once after reset, then settle in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= C_RESET_STATE;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == C_CLR_LAST) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            ready <= 1'b0;
          end
        end
        ST_IDLE: begin
          ready <= 1'b1;
        end
        default: begin
          state    <= C_RESET_STATE;
          clr_addr <= '0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RAM write port
  // --------------------------------------------------------------------------
  // RAM array is never reset; the clear sweep is held off while reset is low.
  // Clear and CPU/loader writes are exclusive because the latter need ready.
  always_ff @(posedge clk) begin
    if (reset && (state == ST_CLEAR)) begin
      mem[clr_addr] <= '0;
    end
    if (wr_commit) begin
      mem[addr_bus] <= bus;
    end
    if (load_commit) begin
      mem[load_addr] <= load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Strobe history, handshakes and statistics
  // --------------------------------------------------------------------------
  // Edge detector, loader ack pulse, sticky conflict flag and wrapping counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_clk_q <= 1'b0;
      load_ack  <= 1'b0;
      conflict  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      mem_clk_q <= mem_clk;
      load_ack  <= load_commit;
      conflict  <= conflict | conflict_hit;
      rd_count  <= rd_count + 16'(rd_serve);
      wr_count  <= wr_count + 16'(wr_commit);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_memory_responder
// Description : Scoreboard bench for cpu_memory_responder. Stimulus queues the
//               expected observations; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_memory_responder;

  localparam int K_BUS   = 0;
  localparam int K_READY = 1;
  localparam int K_CONF  = 2;
  localparam int K_RD    = 3;
  localparam int K_WR    = 4;
  localparam int K_VAL   = 5;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    logic [15:0] act;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_clk;
  logic [7:0]  addr_bus;
  logic        c_ri;
  logic        c_ro;
  wire  [7:0]  bus;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic        load_ack;
  logic        ready;
  logic        conflict;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  // Host side of the shared bus: CPU write data, or a 0x00 probe that exposes
  // any value the responder drives when it must have released the bus.
  logic        drv_en;
  logic [7:0]  drv;
  assign bus = drv_en ? drv : 8'bz;

  chk_t chk_q[$];
  int   ack_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  cpu_memory_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_clk   (mem_clk),
    .addr_bus  (addr_bus),
    .c_ri      (c_ri),
    .c_ro      (c_ro),
    .bus       (bus),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_ack  (load_ack),
    .ready     (ready),
    .conflict  (conflict),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: load_ack pulses against expected commit cycles, then queued checks.
  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [15:0] act;
    if (load_ack === 1'b1) begin
      total++;
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
        void'(ack_q.pop_front());
      end else begin
        bad++;
        $display("FAIL load_ack_unexpected: act=1 exp=0 cyc=%0d", cyc);
      end
    end else if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
      total++;
      bad++;
      $display("FAIL load_ack_missing: act=%b exp=1 cyc=%0d", load_ack, ack_q[0]);
      void'(ack_q.pop_front());
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_BUS:   act = {8'h00, bus};
        K_READY: act = {15'h0, ready};
        K_CONF:  act = {15'h0, conflict};
        K_RD:    act = rd_count;
        K_WR:    act = wr_count;
        default: act = c.act;
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: act=0x%h exp=0x%h cyc=%0d", c.name, act, c.exp, cyc);
      end
    end
  end

  task automatic expect_sig(input int kind, input logic [15:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.act  = '0;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expect_val(input logic [15:0] exp, input logic [15:0] act, input string name);
    chk_t c;
    c.kind = K_VAL;
    c.exp  = exp;
    c.act  = act;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release reset and count edges until ready rises (bounded).
  task automatic release_and_measure(input string name);
    int n;
    n     = 0;
    reset = 1'b1;
    while (ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    expect_val(16'd256, 16'(n), name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b0; mem_clk = 1'b0; addr_bus = 8'h00; c_ri = 1'b0; c_ro = 1'b0;
    load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00; drv_en = 1'b0; drv = 8'h00;
    repeat (3) step();
    expect_sig(K_READY, 16'h0, "rst_ready");
    expect_sig(K_CONF,  16'h0, "rst_conflict");
    expect_sig(K_RD,    16'h0, "rst_rd_count");
    expect_sig(K_WR,    16'h0, "rst_wr_count");
    step();

    // Clear sweep length and cleared contents
    release_and_measure("clear_len");
    c_ro = 1'b1; addr_bus = 8'hFF;
    expect_sig(K_READY, 16'h1,  "ready_idle");
    expect_sig(K_BUS,   16'h00, "rd_ff_cleared");
    step();
    c_ro = 1'b0;

    // Loader write, immediate read, counted read strobe, bus release
    load_we = 1'b1; load_addr = 8'h10; load_data = 8'hAB; ack_q.push_back(cyc + 1);
    step();
    load_we = 1'b0; c_ro = 1'b1; addr_bus = 8'h10;
    expect_sig(K_BUS, 16'hAB, "rd_10");
    step();
    mem_clk = 1'b1;
    expect_sig(K_RD, 16'd0, "rd_cnt_pre");
    step();
    expect_sig(K_RD, 16'd1, "rd_cnt_post");
    addr_bus = 8'hFF;
    expect_sig(K_BUS, 16'h00, "rd_follow_addr");
    step();
    mem_clk = 1'b0; c_ro = 1'b0; addr_bus = 8'h10; drv_en = 1'b1; drv = 8'h00;
    expect_sig(K_BUS, 16'h00, "bus_release_c_ro_low");
    step();
    drv_en = 1'b0;

    // CPU write with mem_clk held for 3 clocks
    addr_bus = 8'h20; c_ri = 1'b1; drv_en = 1'b1; drv = 8'h5C; mem_clk = 1'b1;
    expect_sig(K_WR, 16'd0, "wr_cnt_pre");
    step();
    expect_sig(K_WR, 16'd1, "wr_cnt_1clk");
    step();
    step();
    expect_sig(K_WR, 16'd1, "wr_cnt_held");
    mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0;
    step();
    c_ro = 1'b1;
    expect_sig(K_BUS, 16'h5C, "rd_20");
    step();
    c_ro = 1'b0;

    // Preload words used later
    load_we = 1'b1; load_addr = 8'h40; load_data = 8'h77; ack_q.push_back(cyc + 1);
    step();
    load_addr = 8'hF0; load_data = 8'h99; ack_q.push_back(cyc + 1);
    expect_sig(K_CONF, 16'h0, "conflict_pre");
    step();
    load_we = 1'b0;
    step();

    // Conflict: both requests high across a strobe
    addr_bus = 8'h40; c_ri = 1'b1; c_ro = 1'b1; drv_en = 1'b1; drv = 8'h00; mem_clk = 1'b1;
    expect_sig(K_BUS, 16'h00, "conflict_no_drive");
    step();
    mem_clk = 1'b0;
    expect_sig(K_CONF, 16'h1, "conflict_set");
    expect_sig(K_WR,   16'd1, "conflict_wr_cnt");
    expect_sig(K_RD,   16'd1, "conflict_rd_cnt");
    step();
    c_ri = 1'b0; drv_en = 1'b0;
    expect_sig(K_CONF, 16'h1,  "conflict_sticky");
    expect_sig(K_BUS,  16'h77, "rd_40_unchanged");
    step();
    c_ro = 1'b0;

    // Same-edge CPU and loader writes to one address: CPU wins, no ack
    addr_bus = 8'h30; c_ri = 1'b1; drv_en = 1'b1; drv = 8'h22; mem_clk = 1'b1;
    load_we = 1'b1; load_addr = 8'h30; load_data = 8'h11;
    step();
    load_we = 1'b0; mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0;
    expect_sig(K_WR, 16'd2, "wr_cnt_same_addr");
    step();
    c_ro = 1'b1;
    expect_sig(K_BUS, 16'h22, "rd_30_cpu_wins");
    step();
    c_ro = 1'b0;

    // Same-edge writes to different addresses: both commit
    addr_bus = 8'h31; c_ri = 1'b1; drv_en = 1'b1; drv = 8'h33; mem_clk = 1'b1;
    load_we = 1'b1; load_addr = 8'h32; load_data = 8'h44; ack_q.push_back(cyc + 1);
    step();
    load_we = 1'b0; mem_clk = 1'b0; c_ri = 1'b0; drv_en = 1'b0;
    expect_sig(K_WR, 16'd3, "wr_cnt_diff_addr");
    step();
    c_ro = 1'b1;
    expect_sig(K_BUS, 16'h33, "rd_31_cpu");
    step();
    addr_bus = 8'h32;
    expect_sig(K_BUS, 16'h44, "rd_32_loader");
    step();
    c_ro = 1'b0;

    // Reset with live counters and an active read request
    reset = 1'b0; c_ro = 1'b1; addr_bus = 8'hF0; drv_en = 1'b1; drv = 8'h00;
    expect_sig(K_READY, 16'h0,  "rst2_ready");
    expect_sig(K_RD,    16'd0,  "rst2_rd_count");
    expect_sig(K_WR,    16'd0,  "rst2_wr_count");
    expect_sig(K_CONF,  16'h0,  "rst2_conflict");
    expect_sig(K_BUS,   16'h00, "rst2_bus_release");
    step();
    c_ro = 1'b0; drv_en = 1'b0;

    // Run the sweep to clr_addr=100 while poking CPU and loader (all ignored)
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin
        addr_bus = 8'h90; c_ri = 1'b1; drv_en = 1'b1; drv = 8'h55; mem_clk = 1'b1;
      end
      if (i == 11) begin
        c_ri = 1'b0; drv_en = 1'b0; mem_clk = 1'b0;
      end
      if (i == 20) begin
        load_we = 1'b1; load_addr = 8'hF1; load_data = 8'h66;
      end
      if (i == 22) load_we = 1'b0;
      if (i == 50) begin
        c_ro = 1'b1; addr_bus = 8'hF0; drv_en = 1'b1; drv = 8'h00;
        expect_sig(K_READY, 16'h0,  "clear_ready_low");
        expect_sig(K_BUS,   16'h00, "clear_no_drive");
      end
      if (i == 51) begin
        c_ro = 1'b0; drv_en = 1'b0;
      end
      step();
    end
    expect_sig(K_WR, 16'd0, "clear_ignores_cpu");

    // Reset mid-sweep, then the sweep must restart and run a full length
    reset = 1'b0;
    expect_sig(K_READY, 16'h0, "rst3_ready");
    step();
    release_and_measure("clear_len_restart");
    c_ro = 1'b1; addr_bus = 8'hF0;
    expect_sig(K_BUS, 16'h00, "rd_f0_cleared");
    step();
    c_ro = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
